// File: rtl/mem_bus_pkg.sv
// Shared types and widths for the memory bus controller.
package mem_bus_pkg;

  localparam int MEM_ADDR_W = 8;
  localparam int MEM_DATA_W = 16;

  // Controller sequence: IDLE -> (WAIT) -> ACCESS -> RESP -> IDLE
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  // Kind of the transaction captured in IDLE
  typedef enum logic [1:0] {
    KIND_I_RD = 2'd0,
    KIND_D_RD = 2'd1,
    KIND_D_WR = 2'd2
  } kind_e;

endpackage

// File: rtl/mem_wait_cnt.sv
// 3-bit wait-state down-counter: load, decrement, zero flag.
module mem_wait_cnt (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [2:0] load_val,
  input  logic       dec,
  output logic       zero
);

  logic [2:0] cnt_q, cnt_d;

  // Next count: load wins over decrement; saturate at zero
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != 3'd0)) begin
      cnt_d = cnt_q - 3'd1;
    end
  end

  // Count register
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    if (rst) cnt_q <= 3'd0;
    else     cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == 3'd0);

endmodule

// File: rtl/mem_bus_ctrl.sv
// Memory bus controller: arbitrates instruction and data requests onto a
// single synchronous RAM port. Wait states are enabled by macro
// MEM_BUS_WAIT_EN; without it the controller runs with zero wait states.
module mem_bus_ctrl
  import mem_bus_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [MEM_ADDR_W-1:0] i_addr_bus,
  input  logic                  signal_read_I_mem,
  input  logic [MEM_ADDR_W-1:0] d_addr_bus,
  input  logic                  signal_read_D_mem,
  input  logic                  signal_write_D_mem,
  input  logic [MEM_DATA_W-1:0] d_wdata,
  output logic [MEM_DATA_W-1:0] i_rdata,
  output logic                  i_valid,
  output logic [MEM_DATA_W-1:0] d_rdata,
  output logic                  d_valid,
  output logic                  busy,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [MEM_ADDR_W-1:0] ram_addr,
  output logic [MEM_DATA_W-1:0] ram_wdata,
  input  logic [MEM_DATA_W-1:0] ram_rdata
);

`ifdef MEM_BUS_WAIT_EN
  localparam int unsigned WAIT_EFF = WAIT_CYCLES;
`else
  // Wait states disabled in this build: WAIT_CYCLES has no effect.
  localparam int unsigned WAIT_EFF = WAIT_CYCLES * 0;
`endif
  // Counter is loaded with WAIT_EFF-1 so the zero flag marks the last WAIT cycle
  localparam logic [2:0] WAIT_LOAD = (WAIT_EFF == 0) ? 3'd0 : 3'(WAIT_EFF - 1);

  state_e                state_q, state_d;
  kind_e                 kind_q, kind_d;
  logic [MEM_ADDR_W-1:0] addr_q, addr_d;
  logic [MEM_DATA_W-1:0] wdata_q, wdata_d;
  logic                  pend_q, pend_d;
  logic [MEM_ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic [MEM_DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [MEM_DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic                  i_valid_q, i_valid_d;
  logic                  d_valid_q, d_valid_d;
  logic                  take;
  logic                  cnt_load, cnt_dec, cnt_zero;

  mem_wait_cnt u_wait_cnt (
    .clk      (clk),
    .rst      (reset),
    .load     (cnt_load),
    .load_val (WAIT_LOAD),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // Next-state, request capture and response logic
  always_comb begin
    state_d     = state_q;
    kind_d      = kind_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    i_valid_d   = 1'b0;
    d_valid_d   = 1'b0;
    take        = 1'b0;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pend_q) begin
          // A deferred fetch goes first, even if the I request has dropped
          kind_d = KIND_I_RD;
          addr_d = pend_addr_q;
          pend_d = 1'b0;
          take   = 1'b1;
        end else if (signal_write_D_mem || signal_read_D_mem) begin
          // Data wins; a write masks a simultaneous read
          kind_d  = signal_write_D_mem ? KIND_D_WR : KIND_D_RD;
          addr_d  = d_addr_bus;
          wdata_d = d_wdata;
          take    = 1'b1;
          if (signal_read_I_mem) begin
            pend_d      = 1'b1;
            pend_addr_d = i_addr_bus;
          end
        end else if (signal_read_I_mem) begin
          kind_d = KIND_I_RD;
          addr_d = i_addr_bus;
          take   = 1'b1;
        end

        if (take) begin
          if (WAIT_EFF != 0) begin
            state_d  = ST_WAIT;
            cnt_load = 1'b1;
          end else begin
            state_d  = ST_ACCESS;
          end
        end
      end

      ST_WAIT: begin
        cnt_dec = 1'b1;
        if (cnt_zero) state_d = ST_ACCESS;
      end

      ST_ACCESS: state_d = ST_RESP;

      ST_RESP: begin
        // RAM data is valid now; register it and pulse the matching valid
        state_d = ST_IDLE;
        if (kind_q == KIND_I_RD) begin
          i_valid_d = 1'b1;
          i_rdata_d = ram_rdata;
        end else begin
          d_valid_d = 1'b1;
          if (kind_q == KIND_D_RD) d_rdata_d = ram_rdata;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any access in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      kind_q      <= KIND_I_RD;
      addr_q      <= '0;
      wdata_q     <= '0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      i_valid_q   <= 1'b0;
      d_valid_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      kind_q      <= kind_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      i_valid_q   <= i_valid_d;
      d_valid_q   <= d_valid_d;
    end
  end

  assign ram_en    = (state_q == ST_ACCESS);
  assign ram_we    = ram_en && (kind_q == KIND_D_WR);
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;
  assign busy      = (state_q != ST_IDLE) || pend_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign i_valid   = i_valid_q;
  assign d_valid   = d_valid_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Self-checking bench for mem_bus_ctrl with a synchronous RAM model and a
// queue-based scoreboard. Expected latency follows MEM_BUS_WAIT_EN.
module tb_mem_bus_ctrl;

  localparam int TB_WAIT = 2;
`ifdef MEM_BUS_WAIT_EN
  localparam int LAT = 3 + TB_WAIT;
`else
  localparam int LAT = 3;
`endif

  typedef struct {
    bit          is_i;
    logic [15:0] data;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  i_addr_bus = '0;
  logic        signal_read_I_mem = 1'b0;
  logic [7:0]  d_addr_bus = '0;
  logic        signal_read_D_mem = 1'b0;
  logic        signal_write_D_mem = 1'b0;
  logic [15:0] d_wdata = '0;
  logic [15:0] i_rdata, d_rdata, ram_wdata;
  logic [15:0] ram_rdata = '0;
  logic        i_valid, d_valid, busy, ram_en, ram_we;
  logic [7:0]  ram_addr;

  logic [15:0] mem [256];
  exp_t        sb_q[$];
  int          cyc = 0;
  int          we_cnt = 0;
  int          total = 0;
  int          bad = 0;
  logic [15:0] exp_d = '0;

  mem_bus_ctrl #(.WAIT_CYCLES(TB_WAIT)) dut (
    .clk                (clk),
    .reset              (reset),
    .i_addr_bus         (i_addr_bus),
    .signal_read_I_mem  (signal_read_I_mem),
    .d_addr_bus         (d_addr_bus),
    .signal_read_D_mem  (signal_read_D_mem),
    .signal_write_D_mem (signal_write_D_mem),
    .d_wdata            (d_wdata),
    .i_rdata            (i_rdata),
    .i_valid            (i_valid),
    .d_rdata            (d_rdata),
    .d_valid            (d_valid),
    .busy               (busy),
    .ram_en             (ram_en),
    .ram_we             (ram_we),
    .ram_addr           (ram_addr),
    .ram_wdata          (ram_wdata),
    .ram_rdata          (ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous read-first RAM
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pop and compare on every valid pulse
  always @(negedge clk) begin
    if (ram_we) we_cnt++;
    if (i_valid || d_valid) begin
      if (i_valid && d_valid) begin
        check("both_valid", 32'd1, 32'd0);
      end else if (sb_q.size() == 0) begin
        check("unexpected_valid", {30'd0, i_valid, d_valid}, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("resp_kind", {31'd0, i_valid}, {31'd0, e.is_i});
        check("resp_data", i_valid ? {16'd0, i_rdata} : {16'd0, d_rdata}, {16'd0, e.data});
        check("resp_cycle", cyc, e.cyc);
      end
    end
  end

  // Drive one request at a negedge; returns at the negedge after the sampling edge
  task automatic issue(input bit i_rd, input logic [7:0] ia, input bit d_rd, input bit d_wr,
                       input logic [7:0] da, input logic [15:0] wd,
                       input logic [15:0] exp_i, output int n);
    exp_t e;
    bit   has_d;
    has_d = d_rd || d_wr;
    signal_read_I_mem  = i_rd;
    i_addr_bus         = ia;
    signal_read_D_mem  = d_rd;
    signal_write_D_mem = d_wr;
    d_addr_bus         = da;
    d_wdata            = wd;
    n = cyc + 1;
    if (has_d) begin
      if (d_wr == 1'b0) exp_d = mem[da];
      e.is_i = 1'b0; e.data = exp_d; e.cyc = n + LAT - 1;
      sb_q.push_back(e);
    end
    if (i_rd) begin
      e.is_i = 1'b1; e.data = exp_i; e.cyc = n + LAT - 1 + (has_d ? LAT : 0);
      sb_q.push_back(e);
    end
    @(negedge clk);
    signal_read_I_mem  = 1'b0;
    signal_read_D_mem  = 1'b0;
    signal_write_D_mem = 1'b0;
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (sb_q.size() != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check(name, sb_q.size(), 0);
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_i_rdata"}, {16'd0, i_rdata}, 32'd0);
    check({tag, "_d_rdata"}, {16'd0, d_rdata}, 32'd0);
    check({tag, "_valids"},  {30'd0, i_valid, d_valid}, 32'd0);
    check({tag, "_busy"},    {31'd0, busy}, 32'd0);
    check({tag, "_ram_ctl"}, {30'd0, ram_en, ram_we}, 32'd0);
    check({tag, "_ram_addr"}, {24'd0, ram_addr}, 32'd0);
    check({tag, "_ram_wdata"}, {16'd0, ram_wdata}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, we0, low;
    for (int a = 0; a < 256; a++) mem[a] = {a[7:0], ~a[7:0]};
    mem[8'h10] = 16'hA5A5;

    // Reset state
    #2;
    check_all_zero("reset");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("idle_after_reset");

    // I-read 0x10 -> 0xA5A5
    issue(1'b1, 8'h10, 1'b0, 1'b0, 8'h00, 16'h0000, 16'hA5A5, n);
    drain("drain_ifetch");

    // D-write 0x1234 to 0x80, then D-read back
    we0 = we_cnt;
    issue(1'b0, 8'h00, 1'b0, 1'b1, 8'h80, 16'h1234, 16'h0000, n);
    drain("drain_dwrite");
    check("we_pulse_count", we_cnt - we0, 1);
    check("mem_80", {16'd0, mem[8'h80]}, 32'h1234);
    exp_d = 16'h1234;
    issue(1'b0, 8'h00, 1'b1, 1'b0, 8'h80, 16'h0000, 16'h0000, n);
    drain("drain_dread");
    check("d_rdata_80", {16'd0, d_rdata}, 32'h1234);

    // Coinciding I 0x05 and D-read 0xF0; I drops next cycle
    issue(1'b1, 8'h05, 1'b1, 1'b0, 8'hF0, 16'h0000, 16'h05FA, n);
    low = 0;
    repeat (2 * LAT - 2) begin
      if (!busy) low++;
      @(negedge clk);
    end
    check("busy_held", low, 0);
    @(negedge clk);
    check("busy_released", {31'd0, busy}, 32'd0);
    drain("drain_coincide");

    // Write and read both high at 0x20: write wins, d_rdata unchanged
    issue(1'b0, 8'h00, 1'b1, 1'b1, 8'h20, 16'hBEEF, 16'h0000, n);
    drain("drain_wr_rd");
    check("mem_20", {16'd0, mem[8'h20]}, 32'hBEEF);
    check("d_rdata_kept", {16'd0, d_rdata}, 32'hF00F);

    // Reset during ACCESS of a D-write 0x55AA to 0x30
    signal_write_D_mem = 1'b1;
    d_addr_bus         = 8'h30;
    d_wdata            = 16'h55AA;
    @(negedge clk);
    signal_write_D_mem = 1'b0;
    repeat (LAT - 3) @(negedge clk);
    check("abort_we_before", {31'd0, ram_we}, 32'd1);
    #1 reset = 1'b1;
    #1 check_all_zero("abort");
    @(negedge clk);
    reset = 1'b0;
    exp_d = 16'h0000;
    repeat (LAT + 2) @(negedge clk);
    check("mem_30_untouched", {16'd0, mem[8'h30]}, 32'h30CF);
    check("abort_idle", {31'd0, busy}, 32'd0);

    // Back-to-back I-reads 0x00..0x03 held continuously
    begin
      exp_t e;
      signal_read_I_mem = 1'b1;
      i_addr_bus        = 8'h00;
      n = cyc + 1;
      for (int k = 0; k < 4; k++) begin
        e.is_i = 1'b1;
        e.data = {8'(k), ~8'(k)};
        e.cyc  = n + k * LAT + LAT - 1;
        sb_q.push_back(e);
      end
      for (int k = 1; k < 4; k++) begin
        repeat ((k == 1) ? 1 : LAT) @(negedge clk);
        i_addr_bus = 8'(k);
      end
      repeat (LAT) @(negedge clk);
      signal_read_I_mem = 1'b0;
    end
    drain("drain_b2b");
    check("i_rdata_last", {16'd0, i_rdata}, 32'h03FC);

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
